// File: rtl/vlogic_seq_ctrl.sv
// Sequencer for the vector bitwise-logic datapath (AND/OR/XOR).
// Walks an LMUL register group one VLEN_BITS beat at a time: read vs1/vs2,
// then write op(vs2, vs1) to vd under a tail byte-enable mask.
// Optional feature: define VLOGIC_SEQ_PERF_EN to add perf_insts/perf_busy counters.
module vlogic_seq_ctrl #(
   parameter int unsigned VLEN_BITS = 128,
   parameter int unsigned NREG_BITS = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   issue_valid,
   output logic                   issue_ready,
   input  logic [1:0]             issue_op,
   input  logic                   issue_sew,
   input  logic [1:0]             issue_lmul,
   input  logic [6:0]             issue_vl,
   input  logic [NREG_BITS-1:0]   issue_vd,
   input  logic [NREG_BITS-1:0]   issue_vs1,
   input  logic [NREG_BITS-1:0]   issue_vs2,
   output logic                   rd_en,
   output logic [NREG_BITS-1:0]   rd_addr1,
   output logic [NREG_BITS-1:0]   rd_addr2,
   input  logic [VLEN_BITS-1:0]   rd_data1,
   input  logic [VLEN_BITS-1:0]   rd_data2,
   output logic                   wr_en,
   output logic [NREG_BITS-1:0]   wr_addr,
   output logic [VLEN_BITS-1:0]   wr_data,
   output logic [VLEN_BITS/8-1:0] wr_be,
   output logic                   done,
   output logic                   err
`ifdef VLOGIC_SEQ_PERF_EN
   ,
   output logic [31:0]            perf_insts,
   output logic [31:0]            perf_busy
`endif
);

   localparam int unsigned NBYTES = VLEN_BITS / 8;
   localparam int unsigned E8     = VLEN_BITS / 8;
   localparam int unsigned E32    = VLEN_BITS / 32;

   typedef enum logic [1:0] {StIdle, StRd, StWb, StDone} state_e;

   state_e               state_q;
   logic [1:0]           beat_q;
   logic [1:0]           op_q;
   logic                 sew_q;
   logic [1:0]           lmul_q;
   logic [6:0]           vl_q;
   logic [NREG_BITS-1:0] vd_q;
   logic [NREG_BITS-1:0] vs1_q;
   logic [NREG_BITS-1:0] vs2_q;

   logic [1:0]           issue_mask;
   logic                 issue_illegal;
   logic [1:0]           next_beat;
   logic                 last_beat;

   // Low index bits that must be zero for a group of 2^lmul registers; also the last beat index.
   function automatic logic [1:0] grp_mask(input logic [1:0] lmul);
      unique case (lmul)
         2'd1:    grp_mask = 2'b01;
         2'd2:    grp_mask = 2'b11;
         default: grp_mask = 2'b00;
      endcase
   endfunction

   // Byte b of the beat is written while its element index is below vl.
   function automatic logic [NBYTES-1:0] tail_be(input logic [1:0] beat, input logic sew,
                                                 input logic [6:0] vl);
      logic [NBYTES-1:0] be;
      int unsigned       idx;
      be = '0;
      for (int unsigned j = 0; j < NBYTES; j++) begin
         idx   = sew ? (32'(beat) * E32 + j / 4) : (32'(beat) * E8 + j);
         be[j] = (idx < 32'(vl));
      end
      return be;
   endfunction

   // Decode legality of the offered instruction and beat bookkeeping.
   always_comb begin
      issue_mask    = grp_mask(issue_lmul);
      issue_illegal = (issue_op == 2'b11) || (issue_lmul == 2'b11) ||
                      ((issue_vd[1:0] & issue_mask) != 2'b00) ||
                      ((issue_vs1[1:0] & issue_mask) != 2'b00) ||
                      ((issue_vs2[1:0] & issue_mask) != 2'b00);
      next_beat     = beat_q + 2'd1;
      last_beat     = (beat_q == grp_mask(lmul_q));
   end

   // Sequencer FSM with registered strobes, addresses and enables.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         beat_q      <= 2'd0;
         op_q        <= 2'd0;
         sew_q       <= 1'b0;
         lmul_q      <= 2'd0;
         vl_q        <= 7'd0;
         vd_q        <= '0;
         vs1_q       <= '0;
         vs2_q       <= '0;
         issue_ready <= 1'b1;
         rd_en       <= 1'b0;
         rd_addr1    <= '0;
         rd_addr2    <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_be       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         wr_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (issue_valid) begin
                  op_q        <= issue_op;
                  sew_q       <= issue_sew;
                  lmul_q      <= issue_lmul;
                  vl_q        <= issue_vl;
                  vd_q        <= issue_vd;
                  vs1_q       <= issue_vs1;
                  vs2_q       <= issue_vs2;
                  beat_q      <= 2'd0;
                  issue_ready <= 1'b0;
                  if (issue_illegal || (issue_vl == 7'd0)) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     err     <= issue_illegal;
                  end else begin
                     state_q  <= StRd;
                     rd_en    <= 1'b1;
                     rd_addr1 <= issue_vs1;
                     rd_addr2 <= issue_vs2;
                  end
               end
            end
            StRd: begin
               state_q <= StWb;
               wr_en   <= 1'b1;
               wr_addr <= vd_q + NREG_BITS'(beat_q);
               wr_be   <= tail_be(beat_q, sew_q, vl_q);
            end
            StWb: begin
               if (last_beat) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end else begin
                  state_q  <= StRd;
                  beat_q   <= next_beat;
                  rd_en    <= 1'b1;
                  rd_addr1 <= vs1_q + NREG_BITS'(next_beat);
                  rd_addr2 <= vs2_q + NREG_BITS'(next_beat);
               end
            end
            StDone: begin
               state_q     <= StIdle;
               issue_ready <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Write data comes straight from this cycle's read data; zero outside a write beat.
   always_comb begin
      wr_data = '0;
      if (wr_en) begin
         unique case (op_q)
            2'b00:   wr_data = rd_data2 & rd_data1;
            2'b01:   wr_data = rd_data2 | rd_data1;
            2'b10:   wr_data = rd_data2 ^ rd_data1;
            default: wr_data = '0;
         endcase
      end
   end

`ifdef VLOGIC_SEQ_PERF_EN
   // Completed-instruction and busy-cycle counters, free-running modulo 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_insts <= 32'd0;
         perf_busy  <= 32'd0;
      end else begin
         if (state_q != StIdle) perf_busy <= perf_busy + 32'd1;
         if (state_q == StDone) perf_insts <= perf_insts + 32'd1;
      end
   end
`endif

endmodule
